// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter: shares one S-box ROM between the cipher-round (enc) and
// key-expansion (key) requesters. A grant covers a whole burst of 1..16 bytes.
// Each accepted byte drives the ROM address combinationally. Its substituted
// result returns one cycle later, tagged with the owner that sent it.
// Optional build macro SBOX_ARB_RR_EN: resolve ties round-robin.
// Without it, ties go to key, so key expansion stays ahead of the cipher.
module aes_sbox_arbiter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_enc,
    input  logic [4:0] len_enc,
    input  logic [7:0] din_enc,
    input  logic       dvld_enc,
    input  logic       req_key,
    input  logic [4:0] len_key,
    input  logic [7:0] din_key,
    input  logic       dvld_key,
    output logic       gnt_enc,
    output logic       gnt_key,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] res_data,
    output logic       res_vld_enc,
    output logic       res_vld_key,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_ENC = 2'd1,
        GNT_KEY = 2'd2
    } state_t;

    state_t     state_r;
    logic [4:0] cnt_r;
    logic       gnt_enc_r;
    logic       gnt_key_r;
    logic       res_pend_r;
    logic       owner_tag_r;     // 0 = enc, 1 = key
    logic       busy_r;
`ifdef SBOX_ARB_RR_EN
    logic       rr_ptr_r;        // 0 = enc wins the next tie, 1 = key wins
`endif

    logic       acc_enc_s;
    logic       acc_key_s;
    logic       accept_s;
    logic       last_s;
    logic       pick_enc_s;
    logic       pick_key_s;
    logic       busy_next_s;
    logic [7:0] rom_addr_s;

    // A burst length of 0 or above 16 is treated as a full 16-byte burst.
    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        if ((len == 5'd0) || (len > 5'd16)) begin
            return 5'd16;
        end else begin
            return len;
        end
    endfunction

    // Byte acceptance: only the owner's strobe counts while its grant is up.
    always_comb begin
        acc_enc_s = gnt_enc_r & dvld_enc;
        acc_key_s = gnt_key_r & dvld_key;
        accept_s  = acc_enc_s | acc_key_s;
        last_s    = accept_s & (cnt_r == 5'd1);
        if (acc_enc_s) begin
            rom_addr_s = din_enc;
        end else if (acc_key_s) begin
            rom_addr_s = din_key;
        end else begin
            rom_addr_s = 8'h00;
        end
    end

    // Arbitration between the two requesters, used only when the FSM is idle.
    always_comb begin
        pick_enc_s = 1'b0;
        pick_key_s = 1'b0;
        if (req_enc && req_key) begin
`ifdef SBOX_ARB_RR_EN
            if (rr_ptr_r == 1'b0) begin
                pick_enc_s = 1'b1;
            end else begin
                pick_key_s = 1'b1;
            end
`else
            pick_key_s = 1'b1;
`endif
        end else if (req_enc) begin
            pick_enc_s = 1'b1;
        end else if (req_key) begin
            pick_key_s = 1'b1;
        end else begin
            pick_enc_s = 1'b0;
            pick_key_s = 1'b0;
        end
    end

    // Next busy value: a grant will be held or taken, or a result will be in flight.
    always_comb begin
        if (state_r == IDLE) begin
            busy_next_s = pick_enc_s | pick_key_s;
        end else begin
            busy_next_s = accept_s | ~last_s;
        end
    end

    // Arbiter FSM with burst counter, grants, result tag and busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            cnt_r       <= 5'd0;
            gnt_enc_r   <= 1'b0;
            gnt_key_r   <= 1'b0;
            res_pend_r  <= 1'b0;
            owner_tag_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef SBOX_ARB_RR_EN
            rr_ptr_r    <= 1'b0;
`endif
        end else begin
            res_pend_r <= accept_s;
            busy_r     <= busy_next_s;
            if (accept_s) begin
                owner_tag_r <= acc_key_s;
            end else begin
                owner_tag_r <= owner_tag_r;
            end
            case (state_r)
                IDLE: begin
                    if (pick_enc_s) begin
                        state_r   <= GNT_ENC;
                        gnt_enc_r <= 1'b1;
                        cnt_r     <= clamp_len(len_enc);
`ifdef SBOX_ARB_RR_EN
                        rr_ptr_r  <= 1'b1;
`endif
                    end else if (pick_key_s) begin
                        state_r   <= GNT_KEY;
                        gnt_key_r <= 1'b1;
                        cnt_r     <= clamp_len(len_key);
`ifdef SBOX_ARB_RR_EN
                        rr_ptr_r  <= 1'b0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT_ENC: begin
                    if (acc_enc_s) begin
                        cnt_r <= cnt_r - 5'd1;
                        if (cnt_r == 5'd1) begin
                            state_r   <= IDLE;
                            gnt_enc_r <= 1'b0;
                        end else begin
                            state_r <= GNT_ENC;
                        end
                    end else begin
                        state_r <= GNT_ENC;
                    end
                end
                GNT_KEY: begin
                    if (acc_key_s) begin
                        cnt_r <= cnt_r - 5'd1;
                        if (cnt_r == 5'd1) begin
                            state_r   <= IDLE;
                            gnt_key_r <= 1'b0;
                        end else begin
                            state_r <= GNT_KEY;
                        end
                    end else begin
                        state_r <= GNT_KEY;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    gnt_enc_r <= 1'b0;
                    gnt_key_r <= 1'b0;
                    cnt_r     <= 5'd0;
                end
            endcase
        end
    end

    assign gnt_enc     = gnt_enc_r;
    assign gnt_key     = gnt_key_r;
    assign rom_addr    = rom_addr_s;
    assign res_data    = rom_data;
    assign res_vld_enc = res_pend_r & ~owner_tag_r;
    assign res_vld_key = res_pend_r & owner_tag_r;
    assign busy        = busy_r;

endmodule

// File: doc/aes_sbox_arbiter.md
AES_SBOX_ARBITER -- requirements
Module: aes_sbox_arbiter

Interface
REQ-001 The block SHALL have ports clk (input, 1, clock) and resetn (input, 1): reset resetn, asynchronous, active-low; clock clk.
REQ-002 The block SHALL have req_enc (input, 1), the cipher-round requester's burst request.
REQ-003 The block SHALL have len_enc (input, 5), the cipher burst length in bytes.
REQ-004 The block SHALL have din_enc (input, 8) and dvld_enc (input, 1), the cipher byte and its valid strobe.
REQ-005 The block SHALL have req_key, len_key, din_key and dvld_key (input, 1/5/8/1), the same set for the key-expansion requester.
REQ-006 The block SHALL have gnt_enc and gnt_key (output, 1 each), registered grants, mutually exclusive.
REQ-007 The block SHALL have rom_addr (output, 8), the address to the shared S-box ROM, and rom_data (input, 8), the ROM output one cycle after the address.
REQ-008 The block SHALL have res_data (output, 8), the substituted byte, and res_vld_enc and res_vld_key (output, 1 each), which identify the owner of res_data.
REQ-009 The block SHALL have busy (output, 1), high whenever any grant is active or a result is in flight.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GNT_ENC and GNT_KEY.
REQ-011 In IDLE, one request present SHALL cause a transition to the matching GNT state on the next edge.
REQ-012 In IDLE, both requests present SHALL be resolved per REQ-030/031.
REQ-013 On entry to a GNT state, the owner's len SHALL be latched into a 5-bit remaining counter; len 0 or len greater than 16 SHALL be clamped to 16.
REQ-014 A byte SHALL be accepted only in a cycle where the owner's grant is high and its dvld is high; dvld from the non-owner, or any dvld in IDLE, SHALL be ignored.
REQ-015 rom_addr SHALL equal the owner's din combinationally when a byte is accepted, and SHALL be 8'h00 otherwise.
REQ-016 Each accepted byte SHALL decrement the remaining counter by 1.
REQ-017 On acceptance of the last byte (counter == 1), the FSM SHALL return to IDLE on the next edge; the grant SHALL drop in that same edge, so there is no extra cycle.
REQ-018 Deasserting req during a burst SHALL NOT end the burst; only the byte count ends the grant.
REQ-019 Gaps in dvld SHALL hold the grant and the counter indefinitely.
REQ-020 A registered owner tag SHALL be captured with each accepted byte.
REQ-021 Exactly one cycle after acceptance, the tagged res_vld_x SHALL pulse high for one cycle, with res_data = rom_data passed through combinationally; both res_vld SHALL never be high together.
REQ-022 Arbitration latency SHALL be 1 cycle from req high in IDLE to grant high; best-case throughput is 1 byte/cycle.
REQ-023 The result of the last byte SHALL appear during the IDLE cycle that follows; busy SHALL stay high through that cycle.

Reset
REQ-024 Asserting resetn low SHALL immediately force state IDLE, remaining counter 0, owner tag 0, gnt_enc and gnt_key 0, and res_vld_enc and res_vld_key 0.
REQ-025 Reset SHALL force busy 0 and set the round-robin pointer so that enc wins the first tie.
REQ-026 rom_addr SHALL be 8'h00 during reset.
REQ-027 A reset asserted mid-burst SHALL abandon the burst without emitting any pending result.
REQ-028 After reset release, the block SHALL require a fresh req before any grant is issued.
REQ-029 After reset release, no grant SHALL be issued in the first post-reset cycle unless req is high at that edge.

Configuration
REQ-030 With macro SBOX_ARB_RR_EN defined, ties SHALL be resolved round-robin: the requester not served by the most recent grant wins, and the pointer updates on each grant.
REQ-031 With SBOX_ARB_RR_EN undefined, ties SHALL be resolved by fixed priority: key always wins, because key expansion must run ahead of the cipher round, and no pointer register is built.

Verification
REQ-032 Single enc burst: req_enc=1, len_enc=16, 16 consecutive dvld bytes 0x00..0x0F -> gnt_enc for 16 cycles, then res_vld_enc for 16 cycles lagging acceptance by 1, with res_data 0x63,0x7C,0x77,0x7B...
REQ-033 Tie with SBOX_ARB_RR_EN defined: both requests with len=4 in IDLE -> enc is granted first; after its 4 bytes, key is granted with no idle gap other than the single IDLE cycle.
REQ-034 Tie with SBOX_ARB_RR_EN undefined: both requests in IDLE -> key is granted first; on a repeated tie, key is granted again.
REQ-035 Clamp, stall and non-owner noise: len_key=0 with dvld toggling 1,0,1... and dvld_enc=1 throughout -> exactly 16 key bytes accepted, the grant is held during gaps, and no res_vld_enc occurs.
REQ-036 Reset mid-burst: resetn pulled low after 5 of 16 bytes -> outputs clear asynchronously in the same cycle, there is no res_vld after release, and gnt requires a new req.
REQ-037 Early req drop: req_enc deasserted after byte 2 of 8 -> the grant persists until byte 8 is accepted.
